uart_reg_cmd_ctrl: RTL and testbench

//  Byte-level command controller on the host side of the uart block's FIFOs.

---
 rtl/uart_reg_cmd_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_reg_cmd_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_cmd_ctrl.sv
// uart_reg_cmd_ctrl: decodes 'W'/'R' byte packets from the uart RX FIFO,
// performs one register-bus access, and pushes a one-byte reply to TX.
module uart_reg_cmd_ctrl #(
    parameter int ADDR_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_BITS        = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_empty,
    input  logic [7:0]           r_data,
    output logic                 rd_uart,
    input  logic                 tx_full,
    output logic                 wr_uart,
    output logic [7:0]           w_data,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [7:0]           reg_wdata,
    output logic                 reg_we,
    output logic                 reg_re,
    input  logic [7:0]           reg_rdata,
    output logic                 busy,
    output logic                 cmd_err
);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        REG_WR,
        REG_RD,
        RD_WAIT,
        SEND
    } state_t;

    localparam logic [7:0] CH_W = 8'h57;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_K = 8'h4B;
    localparam logic [7:0] CH_E = 8'h45;
    localparam logic [7:0] CH_T = 8'h54;
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);

    state_t               state, state_nx;
    logic                 op_wr, op_wr_nx;
    logic [ADDR_BITS-1:0] addr_nx;
    logic [7:0]           wdata_nx;
    logic [7:0]           reply, reply_nx;
    logic [TO_BITS-1:0]   to_cnt, to_cnt_nx;
    logic                 err_nx;
    logic                 in_rx;
    logic                 in_get;
    logic                 pop;
    logic                 expire;

    // Byte-consuming states pop whenever the FIFO has data; reset masks strobes.
    assign in_get  = (state == GET_ADDR) || (state == GET_DATA);
    assign in_rx   = (state == IDLE) || in_get;
    assign pop     = in_rx && !rx_empty && !reset;
    assign expire  = in_get && rx_empty && (to_cnt == TO_LAST);

    assign rd_uart = pop;
    assign wr_uart = (state == SEND) && !tx_full && !reset;
    assign reg_we  = (state == REG_WR) && !reset;
    assign reg_re  = (state == REG_RD) && !reset;
    assign w_data  = reply;
    assign busy    = (state != IDLE);

    // Next-state decode, operand latching and inter-byte timeout.
    always_comb begin
        state_nx  = state;
        op_wr_nx  = op_wr;
        addr_nx   = reg_addr;
        wdata_nx  = reg_wdata;
        reply_nx  = reply;
        to_cnt_nx = to_cnt;
        err_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                to_cnt_nx = '0;
                if (pop) begin
                    if (r_data == CH_W || r_data == CH_R) begin
                        op_wr_nx = (r_data == CH_W);
                        state_nx = GET_ADDR;
                    end else begin
                        reply_nx = CH_E;
                        err_nx   = 1'b1;
                        state_nx = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (pop) begin
                    addr_nx   = r_data[ADDR_BITS-1:0];
                    to_cnt_nx = '0;
                    state_nx  = op_wr ? GET_DATA : REG_RD;
                end else if (expire) begin
                    to_cnt_nx = '0;
                    reply_nx  = CH_T;
                    err_nx    = 1'b1;
                    state_nx  = SEND;
                end else begin
                    to_cnt_nx = to_cnt + TO_BITS'(1);
                end
            end
            GET_DATA: begin
                if (pop) begin
                    wdata_nx  = r_data;
                    to_cnt_nx = '0;
                    state_nx  = REG_WR;
                end else if (expire) begin
                    to_cnt_nx = '0;
                    reply_nx  = CH_T;
                    err_nx    = 1'b1;
                    state_nx  = SEND;
                end else begin
                    to_cnt_nx = to_cnt + TO_BITS'(1);
                end
            end
            REG_WR: begin
                reply_nx = CH_K;
                state_nx = SEND;
            end
            REG_RD: begin
                state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                reply_nx = reg_rdata;
                state_nx = SEND;
            end
            SEND: begin
                if (!tx_full) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_wr     <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reply     <= '0;
            to_cnt    <= '0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            op_wr     <= op_wr_nx;
            reg_addr  <= addr_nx;
            reg_wdata <= wdata_nx;
            reply     <= reply_nx;
            to_cnt    <= to_cnt_nx;
            cmd_err   <= err_nx;
        end
    end

endmodule

// File: tb/tb_uart_reg_cmd_ctrl.sv
// tb_uart_reg_cmd_ctrl: directed checks of the uart register command controller
// against a small RX FIFO / register-read model.
module tb_uart_reg_cmd_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       cmd_err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [0:255];
    int head = 0;
    int tail = 0;
    logic [7:0] rd_value = 8'h00;

    int cyc = 0;
    logic pop_pend = 1'b0;
    logic re_pend = 1'b0;
    int pop_cyc = 0, we_cyc = 0, re_cyc = 0, push_cyc = 0, err_cyc = 0;
    int we_cnt = 0, re_cnt = 0, push_cnt = 0, err_cnt = 0;
    int bad_rd = 0, bad_full = 0;
    logic [7:0] we_addr = 0, we_data = 0, re_addr = 0, last_push = 0;

    int s_we, s_re, s_push, s_err;

    assign rx_empty = (head == tail);
    assign r_data   = mem[head[7:0]];

    uart_reg_cmd_ctrl #(
        .ADDR_BITS(8),
        .TIMEOUT_CYCLES(16),
        .TO_BITS(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_empty(rx_empty),
        .r_data(r_data),
        .rd_uart(rd_uart),
        .tx_full(tx_full),
        .wr_uart(wr_uart),
        .w_data(w_data),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we(reg_we),
        .reg_re(reg_re),
        .reg_rdata(reg_rdata),
        .busy(busy),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Observe DUT strobes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        pop_pend = rd_uart;
        re_pend  = reg_re;
        if (rd_uart) begin
            pop_cyc = cyc;
            if (rx_empty) bad_rd++;
        end
        if (reg_we) begin
            we_cnt++; we_cyc = cyc;
            we_addr = reg_addr; we_data = reg_wdata;
        end
        if (reg_re) begin
            re_cnt++; re_cyc = cyc; re_addr = reg_addr;
        end
        if (wr_uart) begin
            push_cnt++; push_cyc = cyc; last_push = w_data;
            if (tx_full) bad_full++;
        end
        if (cmd_err) begin
            err_cnt++; err_cyc = cyc;
        end
    end

    // FIFO pop and register read data, applied just after the edge.
    always @(posedge clk) begin
        #1;
        if (pop_pend) head++;
        reg_rdata = re_pend ? rd_value : 8'h00;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic rx(input logic [7:0] b);
        mem[tail[7:0]] = b;
        tail++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_we = we_cnt; s_re = re_cnt; s_push = push_cnt; s_err = err_cnt;
    endtask

    task automatic wait_push(input string tag, input int budget);
        int start;
        start = push_cnt;
        for (int i = 0; i < budget; i++) begin
            if (push_cnt != start) break;
            tick();
        end
        chk(tag, 32'(push_cnt != start), 32'd1);
    endtask

    initial begin
        reset   = 1'b1;
        tx_full = 1'b0;
        tick(3);
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_err",    32'(cmd_err),   32'd0);
        chk("rst_wr",     32'(wr_uart),   32'd0);
        chk("rst_we",     32'(reg_we),    32'd0);
        chk("rst_re",     32'(reg_re),    32'd0);
        chk("rst_rd",     32'(rd_uart),   32'd0);
        chk("rst_wdata",  32'(w_data),    32'd0);
        chk("rst_addr",   32'(reg_addr),  32'd0);
        reset = 1'b0;
        tick(2);

        // write 57 05 A5
        snap();
        rx(8'h57); rx(8'h05); rx(8'hA5);
        wait_push("w_push_seen", 20);
        chk("w_reply",    32'(last_push),         32'h4B);
        chk("w_we_once",  32'(we_cnt - s_we),     32'd1);
        chk("w_addr",     32'(we_addr),           32'h05);
        chk("w_data",     32'(we_data),           32'hA5);
        chk("w_no_re",    32'(re_cnt - s_re),     32'd0);
        chk("w_no_err",   32'(err_cnt - s_err),   32'd0);
        chk("w_lat_we",   32'(we_cyc - pop_cyc),  32'd1);
        chk("w_lat_tx",   32'(push_cyc - we_cyc), 32'd1);
        tick();
        chk("w_idle",     32'(busy),              32'd0);
        chk("w_one_push", 32'(push_cnt - s_push), 32'd1);
        chk("w_hold_adr", 32'(reg_addr),          32'h05);

        // read 52 05
        snap();
        rd_value = 8'h3C;
        rx(8'h52); rx(8'h05);
        wait_push("r_push_seen", 20);
        chk("r_reply",    32'(last_push),         32'h3C);
        chk("r_re_once",  32'(re_cnt - s_re),     32'd1);
        chk("r_addr",     32'(re_addr),           32'h05);
        chk("r_no_we",    32'(we_cnt - s_we),     32'd0);
        chk("r_lat_re",   32'(re_cyc - pop_cyc),  32'd1);
        chk("r_lat_tx",   32'(push_cyc - re_cyc), 32'd2);

        // bad command 41, then read 52 07
        tick(2);
        snap();
        rd_value = 8'h99;
        rx(8'h41); rx(8'h52); rx(8'h07);
        wait_push("e_push_seen", 20);
        chk("e_reply",    32'(last_push),         32'h45);
        chk("e_err_once", 32'(err_cnt - s_err),   32'd1);
        chk("e_err_cyc",  32'(err_cyc),           32'(push_cyc));
        wait_push("e_rd_seen", 20);
        chk("e_rd_reply", 32'(last_push),         32'h99);
        chk("e_rd_addr",  32'(re_addr),           32'h07);
        chk("e_no_we",    32'(we_cnt - s_we),     32'd0);
        chk("e_err_tot",  32'(err_cnt - s_err),   32'd1);

        // timeout after 57 05
        tick(2);
        snap();
        rx(8'h57); rx(8'h05);
        wait_push("t_push_seen", 40);
        chk("t_reply",    32'(last_push),         32'h54);
        chk("t_err",      32'(err_cnt - s_err),   32'd1);
        chk("t_no_we",    32'(we_cnt - s_we),     32'd0);
        chk("t_no_re",    32'(re_cnt - s_re),     32'd0);
        chk("t_latency",  32'(push_cyc - pop_cyc), 32'd17);
        chk("t_addr",     32'(reg_addr),          32'h05);

        // slow bytes, each gap inside the timeout window
        tick(2);
        snap();
        rx(8'h57);
        tick(10);
        rx(8'h06);
        tick(10);
        rx(8'hC7);
        wait_push("s_push_seen", 20);
        chk("s_reply",    32'(last_push),         32'h4B);
        chk("s_we_once",  32'(we_cnt - s_we),     32'd1);
        chk("s_addr",     32'(we_addr),           32'h06);
        chk("s_data",     32'(we_data),           32'hC7);
        chk("s_no_err",   32'(err_cnt - s_err),   32'd0);

        // read held off by tx_full
        tick(2);
        snap();
        tx_full  = 1'b1;
        rd_value = 8'h5A;
        rx(8'h52); rx(8'h09);
        tick(8);
        chk("f_wr_low",   32'(wr_uart),           32'd0);
        chk("f_busy",     32'(busy),              32'd1);
        chk("f_wdata",    32'(w_data),            32'h5A);
        tick(2);
        chk("f_wdata2",   32'(w_data),            32'h5A);
        chk("f_no_push",  32'(push_cnt - s_push), 32'd0);
        tx_full = 1'b0;
        wait_push("f_push_seen", 5);
        chk("f_reply",    32'(last_push),         32'h5A);
        tick();
        chk("f_one_push", 32'(push_cnt - s_push), 32'd1);
        chk("f_idle",     32'(busy),              32'd0);

        // reset mid-packet, then clean read
        tick(2);
        snap();
        rx(8'h57); rx(8'h05);
        tick(3);
        chk("x_busy_pre", 32'(busy),              32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("x_busy",     32'(busy),              32'd0);
        chk("x_we",       32'(reg_we),            32'd0);
        chk("x_wr",       32'(wr_uart),           32'd0);
        chk("x_err",      32'(cmd_err),           32'd0);
        chk("x_addr",     32'(reg_addr),          32'd0);
        tick(20);
        chk("x_no_push",  32'(push_cnt - s_push), 32'd0);
        chk("x_no_we",    32'(we_cnt - s_we),     32'd0);
        rd_value = 8'hC3;
        rx(8'h52); rx(8'h07);
        wait_push("x_rd_seen", 20);
        chk("x_rd_reply", 32'(last_push),         32'hC3);
        chk("x_rd_addr",  32'(re_addr),           32'h07);
        chk("x_rd_no_we", 32'(we_cnt - s_we),     32'd0);

        // reset while stuck in SEND with tx_full
        tick(2);
        snap();
        tx_full  = 1'b1;
        rd_value = 8'h11;
        rx(8'h52); rx(8'h01);
        tick(8);
        chk("y_busy_pre", 32'(busy),              32'd1);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        tx_full = 1'b0;
        tick(5);
        chk("y_no_push",  32'(push_cnt - s_push), 32'd0);
        chk("y_idle",     32'(busy),              32'd0);

        chk("never_pop_empty", 32'(bad_rd),       32'd0);
        chk("never_push_full", 32'(bad_full),     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
